instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port pc_in, input, 27: fetch address (program counter).
REQ-004 SHALL have port fetch_start, input, 1: one-cycle request pulse; pc_in sampled on same edge.
REQ-005 SHALL have port flush, input, 1: abort in-flight fetch; invalidate cache when compiled in.
REQ-006 SHALL have port bus_addr, output, 27: memory read address.
REQ-007 SHALL have port bus_start, output, 1: one-cycle memory read request.
REQ-008 SHALL have port bus_done, input, 1: one-cycle read-complete strobe; bus_q valid in that cycle.
REQ-009 SHALL have port bus_q, input, 32: memory read data.
REQ-010 SHALL have port instr, output, 32: last fetched instruction word.
REQ-011 SHALL have port fetch_done, output, 1: one-cycle pulse; instr valid from this cycle.
REQ-012 SHALL have port busy, output, 1: high from the edge after accepted fetch_start until the fetch_done edge, or until the aborted read retires.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, DRAIN.
REQ-014 SHALL, in IDLE with fetch_start=1, latch pc_in into an address register and go to REQ; ignore fetch_start in any other state.
REQ-015 SHALL, in REQ, drive bus_addr=latched address, assert bus_start for exactly one cycle, then go to WAIT.
REQ-016 SHALL hold bus_addr stable from REQ until bus_done is sampled.
REQ-017 SHALL, in WAIT on bus_done=1, load instr<=bus_q, pulse fetch_done next cycle, return to IDLE.
REQ-018 SHALL give uncached latency: fetch_start at edge N -> bus_start at N+1 -> fetch_done one cycle after the bus_done edge.
REQ-019 SHALL, on flush in REQ, return to IDLE without asserting bus_start and without fetch_done.
REQ-020 SHALL, on flush in WAIT without bus_done, go to DRAIN; on DRAIN bus_done return to IDLE, leaving instr unchanged and fetch_done low.
REQ-021 SHALL treat flush and bus_done in the same WAIT cycle as flush: data discarded, return to IDLE, no fetch_done.
REQ-022 SHALL give flush priority over fetch_start when both arrive in IDLE (request dropped).
REQ-023 SHALL hold instr stable between fetch_done pulses.

Reset
REQ-024 SHALL, on reset asserted, immediately force state=IDLE, instr=0, fetch_done=0, bus_start=0, busy=0, bus_addr=0, address register=0.
REQ-025 SHALL abandon an in-flight read on reset; a bus_done arriving after reset release in IDLE SHALL be ignored.
REQ-026 SHALL clear all cache valid bits on reset when the cache is compiled in.

Configuration
REQ-027 SHALL compile a 16-entry direct-mapped instruction cache only when INSTR_FETCH_CACHE_EN is defined.
REQ-028 With INSTR_FETCH_CACHE_EN: index=pc_in[3:0], tag=pc_in[26:4], one valid bit per entry.
REQ-029 With INSTR_FETCH_CACHE_EN: a hit on accepted fetch_start SHALL load instr from cache and pulse fetch_done next cycle, with no bus_start and busy kept low.
REQ-030 With INSTR_FETCH_CACHE_EN: addresses >= 27'hC00000 (ROM/IO) SHALL never hit or fill; a completed uncached-region miss SHALL fill index/tag/data and set valid.
REQ-031 With INSTR_FETCH_CACHE_EN: flush SHALL clear all valid bits in one cycle; an aborted read SHALL not fill.
REQ-032 Without INSTR_FETCH_CACHE_EN: every fetch SHALL go to the bus; no cache storage SHALL be synthesized.

Verification
REQ-033 Reset, fetch_start with pc_in=27'h000010, bus_done 3 cycles after bus_start with bus_q=32'hDEADBEEF -> one bus_start with bus_addr=27'h000010, instr=32'hDEADBEEF, one fetch_done, busy high throughout.
REQ-034 fetch_start pulsed again while in WAIT -> ignored; exactly one bus_start and one fetch_done.
REQ-035 flush in WAIT, then bus_done with bus_q=32'h12345678 -> instr keeps prior value, no fetch_done, busy drops after bus_done; the next fetch proceeds normally.
REQ-036 Reset asserted in WAIT, then bus_done after release -> all outputs 0, FSM IDLE, no fetch_done.
REQ-037 INSTR_FETCH_CACHE_EN: two fetches of 27'h000025 -> first uses the bus, second has no bus_start and fetch_done one cycle after start with the same data; fetch of 27'h000035 (same index) -> miss; repeated 27'hC02422 -> bus every time.
REQ-038 INSTR_FETCH_CACHE_EN: fill 27'h000025, flush, refetch -> miss with bus_start asserted.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if -- memory read bus between the instruction fetch unit and
// program memory.
//   bus_addr  [26:0]  read address, held stable for the whole read
//   bus_start         one-cycle read request
//   bus_done          one-cycle read-complete strobe, bus_q valid with it
//   bus_q     [31:0]  read data
// master: the fetch unit (issues reads); slave: the memory.
interface instr_fetch_if;
    logic [26:0] bus_addr;
    logic        bus_start;
    logic        bus_done;
    logic [31:0] bus_q;

    modport master (output bus_addr, output bus_start,
                    input  bus_done, input  bus_q);
    modport slave  (input  bus_addr, input  bus_start,
                    output bus_done, output bus_q);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch -- single-outstanding instruction fetch unit.
//   clk               sole clock, rising edge
//   reset             asynchronous, active-high
//   pc_in     [26:0]  fetch address, sampled with fetch_start
//   fetch_start       one-cycle fetch request (honoured only when idle)
//   flush             abort the in-flight fetch / invalidate the cache
//   bus               instr_fetch_if.master memory read port
//   instr     [31:0]  last fetched instruction word
//   fetch_done        one-cycle pulse, instr valid from this cycle
//   busy              a bus read is outstanding
// Optional 16-entry direct-mapped cache: define INSTR_FETCH_CACHE_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no read outstanding, accepting fetch_start
// REQ   | bus_start driven for one cycle with the latched address
// WAIT  | read outstanding, waiting for bus_done
// DRAIN | read aborted by flush, waiting for bus_done to retire it
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] pc_in,
    input  logic        fetch_start,
    input  logic        flush,
    instr_fetch_if.master bus,
    output logic [31:0] instr,
    output logic        fetch_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t      state, state_next;
    logic [26:0] addr_q;
    logic [31:0] instr_q;
    logic        done_q;
    logic        start_miss;
    logic        start_hit;
    logic        complete;
    logic        bus_start_c;
    logic        hit;
    logic [31:0] hit_data;

`ifdef INSTR_FETCH_CACHE_EN
    logic [15:0] valid_q;
    logic [22:0] tag_mem  [16];
    logic [31:0] data_mem [16];
    logic        fill;

    // The ROM/IO region at and above 27'hC00000 is never cached.
    assign hit      = (pc_in < 27'hC00000) && valid_q[pc_in[3:0]]
                      && (tag_mem[pc_in[3:0]] == pc_in[26:4]);
    assign hit_data = data_mem[pc_in[3:0]];
    assign fill     = complete && (addr_q < 27'hC00000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid_q <= '0;
        else if (flush)
            valid_q <= '0;
        else if (fill)
            valid_q[addr_q[3:0]] <= 1'b1;
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[addr_q[3:0]]  <= addr_q[26:4];
            data_mem[addr_q[3:0]] <= bus.bus_q;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_miss  = 1'b0;
        start_hit   = 1'b0;
        complete    = 1'b0;
        bus_start_c = 1'b0;
        case (state)
            IDLE: begin
                // flush wins over a simultaneous request; the request is dropped
                if (fetch_start && !flush) begin
                    if (hit) begin
                        start_hit = 1'b1;
                    end else begin
                        start_miss = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // bus_start is gated by flush so an aborted request never reaches memory
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    bus_start_c = 1'b1;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (flush)
                    state_next = bus.bus_done ? IDLE : DRAIN;
                else if (bus.bus_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (bus.bus_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            if (start_miss || start_hit)
                addr_q <= pc_in;
            if (complete)
                instr_q <= bus.bus_q;
            else if (start_hit)
                instr_q <= hit_data;
            done_q <= complete || start_hit;
        end
    end

    assign bus.bus_addr  = addr_q;
    assign bus.bus_start = bus_start_c;
    assign instr         = instr_q;
    assign fetch_done    = done_q;
    assign busy          = (state != IDLE);
endmodule
